// File: rtl/a_buf_ctrl.sv
// a_buf_ctrl: ping-pong controller for the two-bank A operand buffer.
// One bank fills from the load stream while the other drains row
// addresses to the systolic array.
// Optional stall counters are compiled in with `define A_BUF_CTRL_PERF_EN.
module a_buf_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cfg_len_i,
    input  logic              flush_i,
    input  logic              ld_valid_i,
    output logic              ld_ready_o,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              wr_a_buf_valid_o,
    output logic              wr_a_buf_id_o,
    output logic [CNT_W-1:0]  wr_a_buf_addr_o,
    output logic [DATA_W-1:0] wr_a_buf_data_o,
    input  logic              drain_en_i,
    output logic              rd_a_buf_valid_o,
    output logic              rd_a_buf_id_o,
    output logic [CNT_W-1:0]  rd_a_buf_addr_o,
    output logic              tile_ready_o,
    output logic              tile_done_o,
    output logic [31:0]       fill_stall_cnt_o,
    output logic [31:0]       drain_stall_cnt_o
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t      state_q [0:1];
    bank_state_t      state_d [0:1];
    logic [CNT_W-1:0] len_q   [0:1];
    logic [CNT_W-1:0] len_d   [0:1];
    logic             wr_bank_q, wr_bank_d;
    logic [CNT_W-1:0] wr_cnt_q,  wr_cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] rd_cnt_q,  rd_cnt_d;

    logic             wr_fire;
    logic             wr_first;
    logic [CNT_W-1:0] cfg_len_clamped;
    logic [CNT_W-1:0] wr_len;
    logic             rd_avail;
    logic             rd_issue;
    logic             rd_last;

    logic             vld_p1;
    logic             rd_id_p1;
    logic [CNT_W-1:0] rd_addr_p1;
    logic             done_p1;

    // Next-state for both bank FSMs plus the fill/drain pointers.
    always_comb begin
        state_d[0] = state_q[0];
        state_d[1] = state_q[1];
        len_d[0]   = len_q[0];
        len_d[1]   = len_q[1];
        wr_bank_d  = wr_bank_q;
        wr_cnt_d   = wr_cnt_q;
        rd_bank_d  = rd_bank_q;
        rd_cnt_d   = rd_cnt_q;

        // A tile never exceeds the bank depth, even if DEPTH is not 2**CNT_W.
        cfg_len_clamped = (32'(cfg_len_i) > 32'(DEPTH - 1)) ? CNT_W'(DEPTH - 1) : cfg_len_i;

        // Ready is also dropped during flush so no beat is accepted and then lost.
        ld_ready_o = !rst && !flush_i &&
                     (state_q[wr_bank_q] == EMPTY || state_q[wr_bank_q] == FILLING);
        wr_fire    = ld_valid_i && ld_ready_o;
        wr_first   = (state_q[wr_bank_q] == EMPTY);
        // First beat of a tile compares against the live length being latched.
        wr_len     = wr_first ? cfg_len_clamped : len_q[wr_bank_q];

        rd_avail   = (state_q[rd_bank_q] == FULL) || (state_q[rd_bank_q] == DRAINING);
        rd_issue   = drain_en_i && rd_avail && !flush_i && !rst;
        rd_last    = (rd_cnt_q == len_q[rd_bank_q]);

        if (wr_fire) begin
            if (wr_first) begin
                len_d[wr_bank_q] = cfg_len_clamped;
            end
            if (wr_cnt_q == wr_len) begin
                state_d[wr_bank_q] = FULL;
                wr_cnt_d           = '0;
                wr_bank_d          = !wr_bank_q;
            end else begin
                state_d[wr_bank_q] = FILLING;
                wr_cnt_d           = wr_cnt_q + 1'b1;
            end
        end

        // Fill and drain never touch the same bank in one cycle, so both apply.
        if (rd_issue) begin
            if (rd_last) begin
                state_d[rd_bank_q] = EMPTY;
                rd_cnt_d           = '0;
                rd_bank_d          = !rd_bank_q;
            end else begin
                state_d[rd_bank_q] = DRAINING;
                rd_cnt_d           = rd_cnt_q + 1'b1;
            end
        end

        if (flush_i) begin
            state_d[0] = EMPTY;
            state_d[1] = EMPTY;
            wr_bank_d  = 1'b0;
            wr_cnt_d   = '0;
            rd_bank_d  = 1'b0;
            rd_cnt_d   = '0;
        end
    end

    // Bank state and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_bank_q  <= wr_bank_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_bank_q  <= rd_bank_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Tile lengths are plain data; only meaningful once a bank has been filled.
    always_ff @(posedge clk) begin
        len_q[0] <= len_d[0];
        len_q[1] <= len_d[1];
    end

    // ---- stage p1: registered read issue towards the array ----
    // Read strobe, id and address are zero whenever no row is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            rd_id_p1   <= 1'b0;
            rd_addr_p1 <= '0;
            done_p1    <= 1'b0;
        end else begin
            vld_p1     <= rd_issue;
            rd_id_p1   <= rd_issue ? rd_bank_q : 1'b0;
            rd_addr_p1 <= rd_issue ? rd_cnt_q : '0;
            done_p1    <= rd_issue && rd_last;
        end
    end

    assign wr_a_buf_valid_o = wr_fire;
    assign wr_a_buf_id_o    = wr_bank_q;
    assign wr_a_buf_addr_o  = wr_cnt_q;
    assign wr_a_buf_data_o  = ld_data_i;

    assign rd_a_buf_valid_o = vld_p1;
    assign rd_a_buf_id_o    = rd_id_p1;
    assign rd_a_buf_addr_o  = rd_addr_p1;
    assign tile_done_o      = done_p1;
    assign tile_ready_o     = (state_q[rd_bank_q] == FULL);

`ifdef A_BUF_CTRL_PERF_EN
    logic [31:0] fill_stall_q;
    logic [31:0] drain_stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating stall counters, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            fill_stall_q  <= '0;
            drain_stall_q <= '0;
        end else begin
            if (ld_valid_i && !ld_ready_o) fill_stall_q  <= sat_inc(fill_stall_q);
            if (drain_en_i && !rd_avail)   drain_stall_q <= sat_inc(drain_stall_q);
        end
    end

    assign fill_stall_cnt_o  = fill_stall_q;
    assign drain_stall_cnt_o = drain_stall_q;
`else
    assign fill_stall_cnt_o  = 32'd0;
    assign drain_stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_a_buf_ctrl.sv
// Scoreboard bench for a_buf_ctrl: the driver runs a tile-queue reference
// model and pushes expected strobes; a monitor pops them as the DUT emits.
module tb_a_buf_ctrl;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [CNT_W-1:0]  cfg_len_i;
    logic              flush_i;
    logic              ld_valid_i;
    logic              ld_ready_o;
    logic [DATA_W-1:0] ld_data_i;
    logic              wr_a_buf_valid_o;
    logic              wr_a_buf_id_o;
    logic [CNT_W-1:0]  wr_a_buf_addr_o;
    logic [DATA_W-1:0] wr_a_buf_data_o;
    logic              drain_en_i;
    logic              rd_a_buf_valid_o;
    logic              rd_a_buf_id_o;
    logic [CNT_W-1:0]  rd_a_buf_addr_o;
    logic              tile_ready_o;
    logic              tile_done_o;
    logic [31:0]       fill_stall_cnt_o;
    logic [31:0]       drain_stall_cnt_o;

    a_buf_ctrl #(.DATA_W(DATA_W), .DEPTH(64), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cfg_len_i(cfg_len_i), .flush_i(flush_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_data_i(ld_data_i),
        .wr_a_buf_valid_o(wr_a_buf_valid_o), .wr_a_buf_id_o(wr_a_buf_id_o),
        .wr_a_buf_addr_o(wr_a_buf_addr_o), .wr_a_buf_data_o(wr_a_buf_data_o),
        .drain_en_i(drain_en_i), .rd_a_buf_valid_o(rd_a_buf_valid_o),
        .rd_a_buf_id_o(rd_a_buf_id_o), .rd_a_buf_addr_o(rd_a_buf_addr_o),
        .tile_ready_o(tile_ready_o), .tile_done_o(tile_done_o),
        .fill_stall_cnt_o(fill_stall_cnt_o), .drain_stall_cnt_o(drain_stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {int due; logic id; logic [CNT_W-1:0] addr; logic [DATA_W-1:0] data;} wr_t;
    typedef struct {int due; logic id; logic [CNT_W-1:0] addr; logic last;} rd_t;
    typedef struct {int due; logic ready; logic tready;} cy_t;
    typedef struct {logic bank; int len;} tile_t;

    wr_t   wq[$];
    rd_t   rq[$];
    cy_t   cq[$];
    tile_t tiles[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Reference model: completed tiles wait in a queue; a tile under fill
    // occupies the other slot. Two slots total, tiles alternate banks.
    bit          f_active = 1'b0;
    logic        f_bank   = 1'b0;
    int          f_cnt    = 0;
    int          f_len    = 0;
    int          d_cnt    = 0;
    logic [31:0] m_fstall = 0;
    logic [31:0] m_dstall = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 1;
    endfunction

    task automatic step(input logic v, input logic en, input logic fl, input int len);
        bit   exp_ready;
        bit   exp_tr;
        bit   have_tile;
        logic [DATA_W-1:0] d;
        @(negedge clk);
`ifdef A_BUF_CTRL_PERF_EN
        chk("fill_stall_cnt", fill_stall_cnt_o, m_fstall);
        chk("drain_stall_cnt", drain_stall_cnt_o, m_dstall);
`else
        chk("fill_stall_cnt", fill_stall_cnt_o, 0);
        chk("drain_stall_cnt", drain_stall_cnt_o, 0);
`endif
        cyc++;
        d          = $urandom;
        ld_valid_i = v;
        drain_en_i = en;
        flush_i    = fl;
        cfg_len_i  = CNT_W'(len);
        ld_data_i  = d;

        have_tile = (tiles.size() > 0);
        exp_ready = !fl && (f_active || tiles.size() < 2);
        exp_tr    = have_tile && d_cnt == 0;
        cq.push_back('{due: cyc, ready: exp_ready, tready: exp_tr});

        if (fl) begin
            m_fstall = 0;
            m_dstall = 0;
        end else begin
            if (v && !exp_ready) m_fstall = sat1(m_fstall);
            if (en && !have_tile) m_dstall = sat1(m_dstall);
        end

        // Drain decision uses only tiles completed before this cycle.
        if (en && !fl && have_tile) begin
            rq.push_back('{due: cyc + 1, id: tiles[0].bank, addr: CNT_W'(d_cnt),
                           last: (d_cnt == tiles[0].len)});
            if (d_cnt == tiles[0].len) begin
                void'(tiles.pop_front());
                d_cnt = 0;
            end else begin
                d_cnt++;
            end
        end

        if (v && exp_ready) begin
            if (!f_active) begin
                f_active = 1'b1;
                f_len    = len;
                f_cnt    = 0;
            end
            wq.push_back('{due: cyc, id: f_bank, addr: CNT_W'(f_cnt), data: d});
            f_cnt++;
            if (f_cnt == f_len + 1) begin
                tiles.push_back('{bank: f_bank, len: f_len});
                f_active = 1'b0;
                f_bank   = ~f_bank;
            end
        end

        if (fl) begin
            tiles.delete();
            f_active = 1'b0;
            f_bank   = 1'b0;
            d_cnt    = 0;
        end
    endtask

    // Monitor: pops expectations as the DUT presents strobes.
    initial begin
        cy_t c;
        wr_t w;
        rd_t r;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (cq.size() > 0 && cq[0].due == cyc) begin
                    c = cq.pop_front();
                    chk("ld_ready", ld_ready_o, c.ready);
                    chk("tile_ready", tile_ready_o, c.tready);
                end
                if (wr_a_buf_valid_o) begin
                    if (wq.size() == 0) begin
                        chk("wr_unexpected", 1, 0);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_time", cyc, w.due);
                        chk("wr_id", wr_a_buf_id_o, w.id);
                        chk("wr_addr", wr_a_buf_addr_o, w.addr);
                        chk("wr_data", wr_a_buf_data_o, w.data);
                    end
                end else if (wq.size() > 0 && wq[0].due <= cyc) begin
                    w = wq.pop_front();
                    chk("wr_missing", 0, 1);
                end
                if (rd_a_buf_valid_o) begin
                    if (rq.size() == 0) begin
                        chk("rd_unexpected", 1, 0);
                    end else begin
                        r = rq.pop_front();
                        chk("rd_time", cyc, r.due);
                        chk("rd_id", rd_a_buf_id_o, r.id);
                        chk("rd_addr", rd_a_buf_addr_o, r.addr);
                        chk("tile_done", tile_done_o, r.last);
                    end
                end else begin
                    if (tile_done_o) chk("tile_done_stray", tile_done_o, 0);
                    if (rq.size() > 0 && rq[0].due <= cyc) begin
                        r = rq.pop_front();
                        chk("rd_missing", 0, 1);
                    end
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        ld_valid_i = 1'b1;
        drain_en_i = 1'b1;
        flush_i    = 1'b0;
        cfg_len_i  = '0;
        ld_data_i  = '0;
        repeat (3) @(negedge clk);
        chk("rst_ld_ready", ld_ready_o, 0);
        chk("rst_wr_valid", wr_a_buf_valid_o, 0);
        chk("rst_rd_valid", rd_a_buf_valid_o, 0);
        chk("rst_rd_addr", rd_a_buf_addr_o, 0);
        chk("rst_tile_ready", tile_ready_o, 0);
        chk("rst_tile_done", tile_done_o, 0);
        chk("rst_fill_stall", fill_stall_cnt_o, 0);
        chk("rst_drain_stall", drain_stall_cnt_o, 0);
        rst        = 1'b0;
        ld_valid_i = 1'b0;
        drain_en_i = 1'b0;
        mon_en     = 1'b1;

        // 4-row tile into bank0, then drain it.
        for (int i = 0; i < 6; i++) step(i < 4, 1'b0, 1'b0, 3);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 3);
        // Drain with 1,0,1,0 enable pattern.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 3);
        for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2 == 0), 1'b0, 3);
        // Continuous 64-row tiles with overlapped, mostly-enabled draining.
        for (int i = 0; i < 400; i++) step(1'b1, 1'(i > 64 && ($urandom % 4 != 0)), 1'b0, 63);
        // Flush mid-drain, then flush mid-fill at wr_cnt=5.
        step(1'b0, 1'b1, 1'b1, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 9);
        step(1'b1, 1'b0, 1'b1, 9);
        step(1'b1, 1'b0, 1'b0, 9);
        step(1'b0, 1'b0, 1'b1, 0);
        // Both banks FULL, loads held for 10 more cycles.
        for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 1'b0, 1);
        // Single-row tiles.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, 0);
        // Random mix.
        for (int i = 0; i < 2000; i++)
            step(1'($urandom % 3 != 0), 1'($urandom % 2), 1'($urandom % 60 == 0),
                 int'($urandom_range(0, 7)));
        // Drain everything left.
        for (int i = 0; i < 150; i++) step(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        #3;
        chk("wr_queue_left", wq.size(), 0);
        chk("rd_queue_left", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
